// File: rtl/fallthrough_queue_axis_reader.sv
// Pops beats from a first-word-fall-through queue and emits a cleaned-up AXI4-Stream:
// empty beats are dropped, trailing empty tlast beats are folded, data-less packets are discarded.
module fallthrough_queue_axis_reader #(
    parameter  int TDATA_WIDTH = 256,
    parameter  int TUSER_WIDTH = 128,
    parameter  int COUNT_WIDTH = 32,
    localparam int TKEEP_WIDTH = TDATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [TDATA_WIDTH-1:0] q_tdata,
    input  logic [TKEEP_WIDTH-1:0] q_tkeep,
    input  logic [TUSER_WIDTH-1:0] q_tuser,
    input  logic                   q_tlast,
    input  logic                   q_can_read,
    output logic                   q_read,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [COUNT_WIDTH-1:0] pkt_count,
    output logic [COUNT_WIDTH-1:0] dropped_beats,
    output logic [COUNT_WIDTH-1:0] empty_pkts
);

    logic                   p_valid;
    logic [TDATA_WIDTH-1:0] p_tdata;
    logic [TKEEP_WIDTH-1:0] p_tkeep;
    logic [TUSER_WIDTH-1:0] p_tuser;
    logic                   p_tlast;

    logic o_free;
    logic q_empty_beat;
    logic p_load;
    logic p_to_o;
    logic fold_last;
    logic drop_beat;
    logic drop_pkt;
    logic handshake;

    assign o_free       = ~m_axis_tvalid | m_axis_tready;
    assign q_empty_beat = (q_tkeep == '0);

    // P is held back until its successor (or its own tlast) proves it is not the last data beat.
    assign q_read    = q_can_read & ~reset &
                       (~p_valid | (~p_tlast & (q_empty_beat | o_free)));
    assign p_load    = q_read & ~q_empty_beat;
    assign p_to_o    = p_valid & o_free & (p_tlast | p_load);
    assign fold_last = q_read & q_empty_beat & q_tlast & p_valid;
    assign drop_beat = q_read & q_empty_beat & ~q_tlast;
    assign drop_pkt  = q_read & q_empty_beat & q_tlast & ~p_valid;
    assign handshake = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge clk) begin
        if (reset) begin
            p_valid <= 1'b0;
            p_tdata <= '0;
            p_tkeep <= '0;
            p_tuser <= '0;
            p_tlast <= 1'b0;
        end else begin
            if (p_load) begin
                p_valid <= 1'b1;
                p_tdata <= q_tdata;
                p_tkeep <= q_tkeep;
                p_tuser <= q_tuser;
                p_tlast <= q_tlast;
            end else if (p_to_o) begin
                p_valid <= 1'b0;
            end
            if (fold_last) begin
                p_tlast <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (p_to_o) begin
            m_axis_tdata  <= p_tdata;
            m_axis_tkeep  <= p_tkeep;
            m_axis_tuser  <= p_tuser;
            m_axis_tlast  <= p_tlast;
            m_axis_tvalid <= 1'b1;
        end else if (handshake) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count     <= '0;
            dropped_beats <= '0;
            empty_pkts    <= '0;
        end else begin
            if (handshake & m_axis_tlast) begin
                pkt_count <= pkt_count + COUNT_WIDTH'(1);
            end
            if (drop_beat) begin
                dropped_beats <= dropped_beats + COUNT_WIDTH'(1);
            end
            if (drop_pkt) begin
                empty_pkts <= empty_pkts + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fallthrough_queue_axis_reader.sv
// Directed bench: a small queue model feeds the reader, AXIS beats are logged and compared
// against hand-computed expectations.
module tb_fallthrough_queue_axis_reader;

    localparam int DW = 32;
    localparam int UW = 8;
    localparam int CW = 32;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] q_tdata;
    logic [KW-1:0] q_tkeep;
    logic [UW-1:0] q_tuser;
    logic          q_tlast;
    logic          q_can_read;
    logic          q_read;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] dropped_beats;
    logic [CW-1:0] empty_pkts;

    fallthrough_queue_axis_reader #(
        .TDATA_WIDTH(DW),
        .TUSER_WIDTH(UW),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .q_tdata      (q_tdata),
        .q_tkeep      (q_tkeep),
        .q_tuser      (q_tuser),
        .q_tlast      (q_tlast),
        .q_can_read   (q_can_read),
        .q_read       (q_read),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .pkt_count    (pkt_count),
        .dropped_beats(dropped_beats),
        .empty_pkts   (empty_pkts)
    );

    always #5 clk = ~clk;

    // queue model contents
    logic [DW-1:0] qd [64];
    logic [KW-1:0] qk [64];
    logic [UW-1:0] qu [64];
    logic          ql [64];
    int            qlen;
    int            qidx;

    // AXIS log
    logic [DW-1:0] od [64];
    logic [KW-1:0] ok [64];
    logic [UW-1:0] ou [64];
    logic          ol [64];
    int            oc [64];
    int            ocnt;

    int  cyc;
    int  rd_count;
    int  n_tests;
    int  n_fail;
    logic        prev_stall;
    logic [63:0] prev_snap;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_q();
        if (qidx < qlen) begin
            q_can_read = 1'b1;
            q_tdata    = qd[qidx];
            q_tkeep    = qk[qidx];
            q_tuser    = qu[qidx];
            q_tlast    = ql[qidx];
        end else begin
            q_can_read = 1'b0;
            q_tdata    = '0;
            q_tkeep    = '0;
            q_tuser    = '0;
            q_tlast    = 1'b0;
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [KW-1:0] k,
                        input logic [UW-1:0] u, input logic l);
        qd[qlen] = d;
        qk[qlen] = k;
        qu[qlen] = u;
        ql[qlen] = l;
        qlen++;
        drive_q();
    endtask

    task automatic cycle();
        logic        rd;
        logic [63:0] snap;
        @(negedge clk);
        snap = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata};
        if (prev_stall) check("stall_stable", snap, prev_snap);
        prev_stall = m_axis_tvalid & ~m_axis_tready;
        prev_snap  = snap;
        if (m_axis_tvalid && m_axis_tready && ocnt < 64) begin
            od[ocnt] = m_axis_tdata;
            ok[ocnt] = m_axis_tkeep;
            ou[ocnt] = m_axis_tuser;
            ol[ocnt] = m_axis_tlast;
            oc[ocnt] = cyc;
            ocnt++;
        end
        rd = q_read;
        if (rd) rd_count++;
        @(posedge clk);
        #1;
        if (rd) qidx++;
        drive_q();
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        qlen       = 0;
        qidx       = 0;
        drive_q();
        run(2);
        reset      = 1'b0;
        ocnt       = 0;
        rd_count   = 0;
        prev_stall = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        cyc = 0;
        ocnt = 0;
        rd_count = 0;
        prev_stall = 1'b0;
        prev_snap = '0;
        m_axis_tready = 1'b1;
        qlen = 0;
        qidx = 0;
        reset = 1'b1;
        drive_q();
        run(2);

        // reset state, q_read blocked during reset
        push(32'hDEAD0000, 4'hF, 8'h01, 1'b1);
        #1;
        check("rst_q_read", q_read, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_counters", {pkt_count, dropped_beats, empty_pkts}, 0);
        do_reset();

        // 3 full beats
        push(32'h11111111, 4'hF, 8'h01, 1'b0);
        push(32'h22222222, 4'hF, 8'h02, 1'b0);
        push(32'h33333333, 4'hF, 8'h03, 1'b1);
        run(8);
        check("t1_ocnt", ocnt, 3);
        check("t1_d0", od[0], 32'h11111111);
        check("t1_d1", od[1], 32'h22222222);
        check("t1_d2", od[2], 32'h33333333);
        check("t1_last", {ol[0], ol[1], ol[2]}, 3'b001);
        check("t1_pkt", pkt_count, 1);
        check("t1_drop", dropped_beats, 0);

        // trailing empty tlast folded onto previous beat
        do_reset();
        push(32'hAAAA0001, 4'hF, 8'h05, 1'b0);
        push(32'hBBBB0002, 4'h3, 8'h06, 1'b0);
        push(32'hCCCC0003, 4'h0, 8'h07, 1'b1);
        run(8);
        check("t2_ocnt", ocnt, 2);
        check("t2_b0", {ol[0], ok[0], ou[0], od[0]}, {1'b0, 4'hF, 8'h05, 32'hAAAA0001});
        check("t2_b1", {ol[1], ok[1], ou[1], od[1]}, {1'b1, 4'h3, 8'h06, 32'hBBBB0002});
        check("t2_pkt", pkt_count, 1);
        check("t2_counts", {dropped_beats, empty_pkts}, 0);

        // empty non-last beat dropped mid-packet
        do_reset();
        push(32'h0C0C0C0C, 4'hF, 8'h01, 1'b0);
        push(32'h99999999, 4'h0, 8'h09, 1'b0);
        push(32'h0D0D0D0D, 4'h1, 8'h02, 1'b1);
        run(8);
        check("t3_ocnt", ocnt, 2);
        check("t3_b0", {ol[0], od[0]}, {1'b0, 32'h0C0C0C0C});
        check("t3_b1", {ol[1], ok[1], ou[1], od[1]}, {1'b1, 4'h1, 8'h02, 32'h0D0D0D0D});
        check("t3_drop", dropped_beats, 1);
        check("t3_empty", empty_pkts, 0);

        // lone empty tlast beat
        do_reset();
        push(32'h12345678, 4'h0, 8'h04, 1'b1);
        run(6);
        check("t4_ocnt", ocnt, 0);
        check("t4_empty", empty_pkts, 1);
        check("t4_reads", rd_count, 1);
        check("t4_pkt", pkt_count, 0);

        // back-to-back 4-beat packets: one bubble between packets
        do_reset();
        for (int i = 0; i < 8; i++) push(32'h50 + i, 4'hF, 8'(i), (i % 4) == 3);
        run(16);
        check("t5_ocnt", ocnt, 8);
        for (int i = 0; i < 8; i++) check("t5_data", {ol[i], od[i]}, {((i % 4) == 3), 32'h50 + i});
        check("t5_gap01", oc[1] - oc[0], 1);
        check("t5_gap23", oc[3] - oc[2], 1);
        check("t5_gap34", oc[4] - oc[3], 2);
        check("t5_gap47", oc[7] - oc[4], 3);
        check("t5_pkt", pkt_count, 2);

        // backpressure mid-packet
        do_reset();
        for (int i = 0; i < 6; i++) push(32'hA0 + i, 4'hF, 8'(i), i == 5);
        run(3);
        m_axis_tready = 1'b0;
        run(5);
        check("t5s_tvalid", m_axis_tvalid, 1);
        check("t5s_q_read", q_read, 0);
        m_axis_tready = 1'b1;
        run(10);
        check("t5s_ocnt", ocnt, 6);
        for (int i = 0; i < 6; i++) check("t5s_data", {ol[i], od[i]}, {(i == 5), 32'hA0 + i});
        check("t5s_pkt", pkt_count, 1);

        // reset mid-packet with O valid
        do_reset();
        push(32'h0, 4'h0, 8'h00, 1'b0);
        push(32'hEEEEEEEE, 4'hF, 8'h01, 1'b1);
        for (int i = 0; i < 4; i++) push(32'hF0 + i, 4'hF, 8'(i), i == 3);
        run(5);
        check("t6_pre_tvalid", m_axis_tvalid, 1);
        check("t6_pre_counts", {pkt_count, dropped_beats}, {32'd1, 32'd1});
        reset = 1'b1;
        qlen = 0;
        qidx = 0;
        drive_q();
        run(1);
        check("t6_tvalid", m_axis_tvalid, 0);
        check("t6_tlast", m_axis_tlast, 0);
        check("t6_counters", {pkt_count, dropped_beats, empty_pkts}, 0);
        reset = 1'b0;
        ocnt = 0;
        push(32'h77770001, 4'hF, 8'h11, 1'b0);
        push(32'h77770002, 4'h7, 8'h12, 1'b1);
        run(8);
        check("t6_ocnt", ocnt, 2);
        check("t6_b0", {ol[0], od[0]}, {1'b0, 32'h77770001});
        check("t6_b1", {ol[1], ok[1], ou[1], od[1]}, {1'b1, 4'h7, 8'h12, 32'h77770002});
        check("t6_pkt", pkt_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
